// File: rtl/alu_pkg.sv
// Shared ALU dispatch definitions.
// Holds the opcode values, FSM state encoding and the queued command layout.
package alu_pkg;

  localparam logic [1:0] MODE_MULU = 2'd0;
  localparam logic [1:0] MODE_DIVU = 2'd1;
  localparam logic [1:0] MODE_AND  = 2'd2;
  localparam logic [1:0] MODE_OR   = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO, DEPTH x 66 bits, with occupancy count.
// Ports: clk, rst_n, push/din, pop/dout (head), count.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [65:0]   din,
  input  logic          pop,
  output logic [65:0]   dout,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [65:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// Queues ALU commands and issues them one at a time to a multi-cycle ALU.
// Ports: cmd_* in, alu_* to/from ALU, res_* result handshake, cmd_count.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_mode,
  input  logic [31:0]   cmd_a,
  input  logic [31:0]   cmd_b,
  output logic          alu_valid,
  output logic [1:0]    alu_mode,
  output logic [31:0]   alu_in_A,
  output logic [31:0]   alu_in_B,
  input  logic          alu_ready,
  input  logic [63:0]   alu_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [63:0]   res_data,
  output logic [1:0]    res_mode,
  output logic [CW-1:0] cmd_count
);

  logic [1:0] state;
  cmd_t       head;
  cmd_t       in_cmd;
  logic       push;
  logic       pop;
  logic       q_empty;

  assign in_cmd    = '{mode: cmd_mode, a: cmd_a, b: cmd_b};
  assign cmd_ready = cmd_count < CW'(DEPTH);
  assign push      = cmd_valid && cmd_ready;
  assign q_empty   = cmd_count == '0;
  assign alu_valid = state == S_ISSUE;

  // Head is taken from idle, or straight after a consumed result.
  assign pop = !q_empty &&
               ((state == S_IDLE) ||
                ((state == S_HOLD) && res_ready));

  cmd_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (in_cmd),
    .pop   (pop),
    .dout  (head),
    .count (cmd_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      alu_mode  <= '0;
      alu_in_A  <= '0;
      alu_in_B  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_mode  <= '0;
    end else begin
      if (pop) begin
        alu_mode <= head.mode;
        alu_in_A <= head.a;
        alu_in_B <= head.b;
      end
      case (state)
        S_IDLE: begin
          if (pop) state <= S_ISSUE;
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_ready) begin
            res_data  <= alu_out;
            res_mode  <= alu_mode;
            res_valid <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= pop ? S_ISSUE : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: ALU stub, queue-level scoreboard,
// directed vectors with literal expectations.
module tb_alu_dispatch;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_mode;
  logic [31:0]   cmd_a;
  logic [31:0]   cmd_b;
  logic          alu_valid;
  logic [1:0]    alu_mode;
  logic [31:0]   alu_in_A;
  logic [31:0]   alu_in_B;
  logic          alu_ready;
  logic [63:0]   alu_out;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_data;
  logic [1:0]    res_mode;
  logic [CW-1:0] cmd_count;

  alu_dispatch #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_valid (alu_valid),
    .alu_mode  (alu_mode),
    .alu_in_A  (alu_in_A),
    .alu_in_B  (alu_in_B),
    .alu_ready (alu_ready),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_mode  (res_mode),
    .cmd_count (cmd_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] alu_fn(input logic [1:0] m,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    case (m)
      MODE_MULU: return {32'd0, a} * {32'd0, b};
      MODE_DIVU: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                 : {a % b, a / b};
      MODE_AND:  return {32'd0, a & b};
      default:   return {32'd0, a | b};
    endcase
  endfunction

  // ALU stub: answers alu_lat cycles after a start pulse.
  int          alu_lat   = 1;
  int          cnt       = 0;
  logic        stray_req = 1'b0;
  logic [1:0]  sm;
  logic [31:0] sa;
  logic [31:0] sb;

  initial begin
    alu_ready = 1'b0;
    alu_out   = '0;
  end

  always @(negedge clk) begin
    alu_ready = 1'b0;
    if (!rst_n) begin
      cnt = 0;
    end else if (stray_req) begin
      alu_ready = 1'b1;
      alu_out   = 64'hDEAD_BEEF_0BAD_F00D;
      stray_req = 1'b0;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        alu_ready = 1'b1;
        alu_out   = alu_fn(sm, sa, sb);
      end
    end else if (alu_valid) begin
      sm  = alu_mode;
      sa  = alu_in_A;
      sb  = alu_in_B;
      cnt = alu_lat;
    end
  end

  // Scoreboard: commands waiting, command in flight, result state.
  cmd_t        pend[$];
  cmd_t        infl[$];
  logic [63:0] got[$];
  logic        rv_m    = 1'b0;
  logic        waiting = 1'b0;
  logic        rising;
  logic        p_push;
  logic        p_rr;
  logic        p_ar;
  logic        p_av;
  logic [63:0] p_rd;
  cmd_t        pc;
  cmd_t        ic;
  cmd_t        last_iss = '0;
  logic [63:0] held_d;
  logic [1:0]  held_m;
  int          issues  = 0;

  always @(posedge clk) begin
    p_push = cmd_valid && cmd_ready;
    pc     = '{mode: cmd_mode, a: cmd_a, b: cmd_b};
    p_rr   = res_ready;
    p_ar   = alu_ready;
    p_av   = alu_valid;
    p_rd   = res_data;
    rising = 1'b0;
    if (!rst_n) begin
      pend.delete();
      infl.delete();
      rv_m     = 1'b0;
      waiting  = 1'b0;
      last_iss = '0;
    end else begin
      if (p_push) pend.push_back(pc);
      if (rv_m && p_rr) begin
        rv_m = 1'b0;
        got.push_back(p_rd);
        if (infl.size() > 0) void'(infl.pop_front());
      end else if (waiting && p_ar) begin
        rv_m    = 1'b1;
        waiting = 1'b0;
        rising  = 1'b1;
      end
      if (p_av) waiting = 1'b1;
      #1;
      if (rst_n) begin
        if (alu_valid) begin
          issues++;
          chk("issue_has_cmd", 64'(pend.size() > 0), 64'd1);
          chk("issue_res_idle", 64'(res_valid), 64'd0);
          chk("issue_one_out", 64'(infl.size()), 64'd0);
          if (pend.size() > 0) begin
            ic = pend.pop_front();
            infl.push_back(ic);
            last_iss = ic;
          end
        end
        chk("alu_mode", 64'(alu_mode), 64'(last_iss.mode));
        chk("alu_in_A", 64'(alu_in_A), 64'(last_iss.a));
        chk("alu_in_B", 64'(alu_in_B), 64'(last_iss.b));
        chk("cmd_count", 64'(cmd_count), 64'(pend.size()));
        chk("cmd_ready", 64'(cmd_ready), 64'(pend.size() < DEPTH));
        chk("res_valid", 64'(res_valid), 64'(rv_m));
        if (rising && infl.size() > 0) begin
          chk("res_data", res_data,
              alu_fn(infl[0].mode, infl[0].a, infl[0].b));
          chk("res_mode", 64'(res_mode), 64'(infl[0].mode));
          held_d = res_data;
          held_m = res_mode;
        end else if (rv_m) begin
          chk("res_data_stable", res_data, held_d);
          chk("res_mode_stable", 64'(res_mode), 64'(held_m));
        end
      end
    end
  end

  task automatic push(input logic [1:0] m, input logic [31:0] a,
                      input logic [31:0] b);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_a     = a;
    cmd_b     = b;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("push_timeout", 64'd1, 64'd0);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (res_valid) return;
    end
    chk("wait_res_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if (pend.size() == 0 && infl.size() == 0 && !rv_m &&
          !res_valid && cmd_count == '0) return;
    end
    chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int i0;
  int gs;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_alu_valid", 64'(alu_valid), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_count", 64'(cmd_count), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    rst_n = 1'b1;

    push(MODE_MULU, 32'd3, 32'd5);
    chk("mulu_lat_t1", 64'(alu_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("mulu_lat_t2", 64'(alu_valid), 64'd1);
    wait_res();
    chk("mulu_data", res_data, 64'h0000_0000_0000_000F);
    chk("mulu_mode", 64'(res_mode), 64'(MODE_MULU));
    drain();

    push(MODE_DIVU, 32'd100, 32'd7);
    wait_res();
    chk("divu_data", res_data, 64'h0000_0002_0000_000E);
    drain();

    @(negedge clk);
    res_ready = 1'b0;
    i0 = issues;
    for (int k = 0; k < 5; k++)
      push(MODE_OR, 32'(k), 32'h100);
    chk("full_count", 64'(cmd_count), 64'd4);
    chk("full_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_mode  = MODE_AND;
    cmd_a     = 32'h1234;
    cmd_b     = 32'h5678;
    repeat (8) @(posedge clk);
    #1;
    chk("full_blocked", 64'(cmd_count), 64'd4);
    chk("one_issue", 64'(issues - i0), 64'd1);
    chk("held_valid", 64'(res_valid), 64'd1);
    chk("held_data", res_data, 64'h0000_0000_0000_0100);
    cmd_valid = 1'b0;
    @(negedge clk);
    res_ready = 1'b1;
    drain();

    @(negedge clk);
    res_ready = 1'b0;
    fork
      begin
        push(MODE_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        push(MODE_OR, 32'h1, 32'h2);
      end
      begin
        repeat (21) @(negedge clk) res_ready = ~res_ready;
      end
    join
    @(negedge clk);
    res_ready = 1'b1;
    drain();
    gs = got.size();
    chk("and_lit", got[gs-2], 64'h0000_0000_F000_F000);
    chk("or_lit", got[gs-1], 64'h0000_0000_0000_0003);

    @(negedge clk);
    res_ready = 1'b0;
    push(MODE_MULU, 32'd7, 32'd9);
    push(MODE_OR, 32'h10, 32'h20);
    push(MODE_AND, 32'hFFFF, 32'h0F0F);
    wait_res();
    @(negedge clk);
    chk("part_count", 64'(cmd_count), 64'd2);
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_mode  = MODE_DIVU;
    cmd_a     = 32'd1000;
    cmd_b     = 32'd10;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("same_edge_count", 64'(cmd_count), 64'd2);
    chk("same_edge_issue", 64'(alu_valid), 64'd1);
    drain();
    gs = got.size();
    chk("ord0", got[gs-4], 64'd63);
    chk("ord1", got[gs-3], 64'h30);
    chk("ord2", got[gs-2], 64'h0F0F);
    chk("ord3", got[gs-1], 64'h64);

    @(posedge clk);
    #1;
    stray_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("stray_ignored", 64'(res_valid), 64'd0);

    alu_lat = 6;
    push(MODE_MULU, 32'd11, 32'd13);
    for (int k = 0; k < 20 && !alu_valid; k++) @(posedge clk) #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_alu_valid", 64'(alu_valid), 64'd0);
    chk("rst2_res_valid", 64'(res_valid), 64'd0);
    chk("rst2_alu_mode", 64'(alu_mode), 64'd0);
    chk("rst2_alu_A", 64'(alu_in_A), 64'd0);
    chk("rst2_alu_B", 64'(alu_in_B), 64'd0);
    chk("rst2_res_data", res_data, 64'd0);
    chk("rst2_res_mode", 64'(res_mode), 64'd0);
    chk("rst2_count", 64'(cmd_count), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst2_ready", 64'(cmd_ready), 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #2;
      chk("rst2_no_result", 64'(res_valid), 64'd0);
    end
    alu_lat = 1;
    push(MODE_AND, 32'hFFFF_0000, 32'h1234_5678);
    wait_res();
    chk("post_rst_and", res_data, 64'h0000_0000_1234_0000);
    chk("post_rst_mode", 64'(res_mode), 64'(MODE_AND));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning command queue entries (power of two, >=2).
REQ-002 The block SHALL have parameter CW, default 3, meaning width of cmd_count (log2(DEPTH)+1).
REQ-003 The block SHALL run on one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: upstream command present.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: command queue can accept.
REQ-008 The block SHALL have ports cmd_mode, input, 2 bits; cmd_a, input, 32 bits; cmd_b, input, 32 bits: opcode and operands.
REQ-009 The block SHALL have port alu_valid, output, 1 bit: one-cycle start pulse to ALU.
REQ-010 The block SHALL have ports alu_mode, output, 2 bits; alu_in_A, output, 32 bits; alu_in_B, output, 32 bits: ALU operands.
REQ-011 The block SHALL have ports alu_ready, input, 1 bit, and alu_out, input, 64 bits: ALU completion pulse and result.
REQ-012 The block SHALL have ports res_valid, output, 1 bit; res_ready, input, 1 bit; res_data, output, 64 bits; res_mode, output, 2 bits: result handshake.
REQ-013 The block SHALL have port cmd_count, output, CW bits: queue occupancy.

Function
REQ-014 cmd_ready SHALL equal (cmd_count < DEPTH) and SHALL NOT depend on cmd_valid; a command is pushed on any edge where cmd_valid && cmd_ready.
REQ-015 Push when full SHALL be impossible; push and pop in the same cycle SHALL leave cmd_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-016 The FSM SHALL have states S_IDLE, S_ISSUE, S_WAIT, S_HOLD.
REQ-017 In S_IDLE with the queue non-empty, the block SHALL load the queue head into the alu_* registers, pop it, and go to S_ISSUE; otherwise it stays in S_IDLE.
REQ-018 In S_ISSUE, alu_valid SHALL be 1 for exactly that cycle, and the block SHALL then go to S_WAIT.
REQ-019 In S_WAIT, on alu_ready=1 the block SHALL register alu_out into res_data and alu_mode into res_mode, set res_valid, and go to S_HOLD.
REQ-020 In S_HOLD, res_valid SHALL stay 1 with res_data and res_mode stable until res_ready=1; on that edge res_valid SHALL clear, and the FSM SHALL go to S_ISSUE (loading and popping the head) if the queue is non-empty, else to S_IDLE.
REQ-021 alu_mode, alu_in_A and alu_in_B SHALL be held stable from load until the next load.
REQ-022 Only one ALU operation SHALL be outstanding; no issue SHALL occur while res_valid=1.
REQ-023 Latency: for a push at edge t into an empty queue with the FSM in S_IDLE, alu_valid SHALL be high in cycle t+2, and res_valid SHALL rise one cycle after alu_ready.
REQ-024 An alu_ready pulse outside S_WAIT SHALL be ignored.
REQ-025 The block SHALL NOT modify data: res_data is alu_out verbatim.

Reset
REQ-026 On rst_n=0, state SHALL go to S_IDLE, queue pointers and cmd_count to 0, alu_valid to 0, res_valid to 0, and alu_mode, alu_in_A, alu_in_B, res_data, res_mode to 0.
REQ-027 Reset mid-operation SHALL discard queued and in-flight commands without emitting a result; cmd_ready SHALL be 1 in the first cycle after release.

Structure
REQ-028 Shared package alu_pkg SHALL hold the mode constants MODE_MULU=0, MODE_DIVU=1, MODE_AND=2, MODE_OR=3 and the FSM state encoding.
REQ-029 The queue SHALL be a sub-module cmd_fifo: synchronous FIFO of DEPTH x 66 bits, with count output and registered storage.

Verification
REQ-030 The bench SHALL push MULU a=3, b=5 with res_ready=1 and check alu_valid at t+2, res_data=0x0000_0000_0000_000F and res_mode=0 one cycle after alu_ready.
REQ-031 The bench SHALL push DIVU a=100, b=7 and check res_data=0x0000_0002_0000_000E.
REQ-032 The bench SHALL push 5 commands back-to-back with res_ready=0 and check that cmd_ready drops once cmd_count=4, that only one issue occurs, and that res_valid holds its value stable.
REQ-033 The bench SHALL push AND 0xF0F0_F0F0 & 0xFF00_FF00, then OR 0x1 | 0x2, with res_ready toggling, and check results 0xF000_F000 then 0x3 in order.
REQ-034 The bench SHALL assert rst_n=0 during S_WAIT of a MULU and check that all outputs go to 0, no result appears, and a subsequent AND command completes normally.
REQ-035 The bench SHALL push at the same edge where a pop occurs from a partially filled queue and check that cmd_count is unchanged and that order is preserved.
